nios_with_onchip_sdram_key_pio: RTL



---
 rtl/nios_with_onchip_sdram_key_pio_if.sv | 25 ++
 rtl/nios_with_onchip_sdram_key_pio.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/nios_with_onchip_sdram_key_pio_if.sv
// Avalon-MM slave bus bundle for the key (push-button/switch) input PIO.
//   address    : word address of the register being accessed
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data, valid one cycle after the address
//   irq        : level interrupt request to the processor
interface nios_with_onchip_sdram_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_with_onchip_sdram_key_pio.sv
// Key input PIO: synchronises an external input bus, detects edges per bit
// into a sticky write-one-to-clear capture register and raises a masked,
// registered level interrupt.
//
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset
//   in_port : asynchronous external inputs (WIDTH bits)
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata, irq)
//
// Register map (word addresses):
//   0 DATA    (RO)   filtered input value
//   1 reserved       reads 0, writes ignored
//   2 IRQMASK (RW)
//   3 EDGECAP (W1C)
//
// Build option: define KEY_PIO_DEBOUNCE_EN to insert a per-bit debounce
// filter (DEBOUNCE_CYCLES consecutive differing samples accept a change).
module nios_with_onchip_sdram_key_pio #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_port,
    nios_with_onchip_sdram_key_pio_if.slave bus
);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, filt;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise, fall, sel, clr;
    logic [1:0]       warm_q, warm_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en;

    // Only writedata[WIDTH-1:0] is meaningful; the rest is deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr_en = bus.chipselect & ~bus.write_n;

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] deb_q, deb_d;
    logic [15:0]      dcnt_q [WIDTH];
    logic [15:0]      dcnt_d [WIDTH];

    // A bit change is accepted only after it has persisted for
    // DEBOUNCE_CYCLES consecutive samples; any return to the accepted
    // value restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < WIDTH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign filt = deb_q;
`else
    assign filt = sync2_q;
`endif

    always_comb begin
        rise = filt & ~prev_q;
        fall = ~filt & prev_q;
        if (EDGE_TYPE == 0) begin
            sel = rise;
        end else if (EDGE_TYPE == 1) begin
            sel = fall;
        end else begin
            sel = rise | fall;
        end
        // prev/filt still hold reset zeros during warm-up; suppress edges
        // until the pipeline is filled with real samples.
        if (warm_q != 2'd3) begin
            sel = '0;
        end

        clr = '0;
        if (wr_en && bus.address == 2'd3) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        // A new edge wins over a simultaneous clear of the same bit.
        cap_d = (cap_q & ~clr) | sel;

        mask_d = mask_q;
        if (wr_en && bus.address == 2'd2) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end

        warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        irq_d  = |(cap_q & mask_q);

        // Loaded every cycle regardless of chipselect; the bus ignores
        // non-selected cycles.
        rdata_d = '0;
        case (bus.address)
            2'd0:    rdata_d[WIDTH-1:0] = filt;
            2'd2:    rdata_d[WIDTH-1:0] = mask_q;
            2'd3:    rdata_d[WIDTH-1:0] = cap_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= filt;
            warm_q  <= warm_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign bus.irq      = irq_q;

endmodule
